lock_reset_sequencer: RTL and testbench

//  Consumes the clock wizard's 10 MHz output (clk_0 here) and its locked_0 flag.

---
 rtl/lock_reset_sequencer.sv | 132 +++++++++++++
 tb/tb_lock_reset_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_reset_sequencer.sv
// ---------------------------------------------------------------------------
// lock_reset_sequencer
//
// Sits directly downstream of the clock wizard. It synchronises the wizard's
// locked_0 flag into the clk_0 domain and qualifies it over a stability
// window. It then releases the system reset and, a fixed hold time later,
// the peripheral reset. A loss of lock after the system reset has been
// released re-asserts both resets, raises a one-cycle lock_lost pulse and
// bumps a saturating loss counter.
//
// Ports
//   clk_0        in   10 MHz clock from the clock wizard
//   rst_n_0      in   asynchronous active-low reset
//   locked_0     in   wizard lock flag, asynchronous to clk_0
//   sys_rst_n    out  active-low system reset (high in REL_SYS and RUN)
//   periph_rst_n out  active-low peripheral reset (high in RUN)
//   ready        out  high while in RUN
//   lock_lost    out  one-cycle pulse on entry to LOST
//   loss_count   out  saturating count of lock-loss events
//   state_o      out  current FSM state encoding (debug)
// ---------------------------------------------------------------------------
module lock_reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int STABLE_CYCLES   = 16,
    parameter int RST_HOLD_CYCLES = 8,
    parameter int LOSS_CNT_W      = 8
) (
    input  logic                  clk_0,
    input  logic                  rst_n_0,
    input  logic                  locked_0,
    output logic                  sys_rst_n,
    output logic                  periph_rst_n,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic [2:0]            state_o
);

    localparam int MAX_CNT = (STABLE_CYCLES > RST_HOLD_CYCLES) ? STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_STABLE    = 3'd1;
    localparam logic [2:0] S_REL_SYS   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_LOST      = 3'd4;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   lock_s;
    logic [2:0]             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   sys_rst_n_reg, periph_rst_n_reg, ready_reg, lock_lost_reg;
    logic [LOSS_CNT_W-1:0]  loss_count_reg;

    // locked_0 is only ever sampled by the first stage of this chain.
    always_ff @(posedge clk_0 or negedge rst_n_0) begin
        if (!rst_n_0) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked_0};
        end
    end

    assign lock_s = sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_WAIT_LOCK: begin
                if (lock_s) state_next = S_STABLE;
            end
            S_STABLE: begin
                // A drop here is just an unqualified lock, not a loss.
                if (!lock_s)                   state_next = S_WAIT_LOCK;
                else if (cnt_reg == STABLE_LAST) state_next = S_REL_SYS;
                else                           cnt_next = cnt_reg + CNT_W'(1);
            end
            S_REL_SYS: begin
                if (!lock_s)                 state_next = S_LOST;
                else if (cnt_reg == HOLD_LAST) state_next = S_RUN;
                else                         cnt_next = cnt_reg + CNT_W'(1);
            end
            S_RUN: begin
                if (!lock_s) state_next = S_LOST;
            end
            S_LOST: begin
                state_next = S_WAIT_LOCK;
            end
            default: begin
                state_next = S_WAIT_LOCK;
            end
        endcase
        // Every state starts its dwell count from zero.
        if (state_next != state_reg) cnt_next = '0;
    end

    // Outputs are decoded from state_next so they change on the same edge
    // as the state and are glitch-free registered values.
    always_ff @(posedge clk_0 or negedge rst_n_0) begin
        if (!rst_n_0) begin
            state_reg        <= S_WAIT_LOCK;
            cnt_reg          <= '0;
            sys_rst_n_reg    <= 1'b0;
            periph_rst_n_reg <= 1'b0;
            ready_reg        <= 1'b0;
            lock_lost_reg    <= 1'b0;
            loss_count_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            sys_rst_n_reg    <= (state_next == S_REL_SYS) || (state_next == S_RUN);
            periph_rst_n_reg <= (state_next == S_RUN);
            ready_reg        <= (state_next == S_RUN);
            lock_lost_reg    <= (state_next == S_LOST);
            if ((state_next == S_LOST) && (state_reg != S_LOST) && (loss_count_reg != '1)) begin
                loss_count_reg <= loss_count_reg + LOSS_CNT_W'(1);
            end
        end
    end

    assign sys_rst_n    = sys_rst_n_reg;
    assign periph_rst_n = periph_rst_n_reg;
    assign ready        = ready_reg;
    assign lock_lost    = lock_lost_reg;
    assign loss_count   = loss_count_reg;
    assign state_o      = state_reg;

endmodule

// File: tb/tb_lock_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lock_reset_sequencer
//
// Directed plus randomized stimulus on locked_0. Expected outputs come from a
// behavioural model that tracks only how many consecutive edges the
// synchronised lock has been seen high since the last restart, whether a
// loss cycle is pending, and the number of losses. The sequencer phase is
// derived arithmetically from that run length. Two instances are driven
// with identical stimulus: the default one and one with a 2-bit loss
// counter to exercise saturation.
// ---------------------------------------------------------------------------
module tb_lock_reset_sequencer;

    localparam int SS = 2;
    localparam int SC = 16;
    localparam int RH = 8;

    logic       clk_0 = 1'b0;
    logic       rst_n_0;
    logic       locked_0;
    logic       sys_rst_n, periph_rst_n, ready, lock_lost;
    logic [7:0] loss_count;
    logic [2:0] state_o;
    logic       b_sys_rst_n, b_periph_rst_n, b_ready, b_lock_lost;
    logic [1:0] b_loss_count;
    logic [2:0] b_state_o;

    always #5 clk_0 = ~clk_0;

    lock_reset_sequencer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .RST_HOLD_CYCLES(RH), .LOSS_CNT_W(8)) dut (
        .clk_0(clk_0), .rst_n_0(rst_n_0), .locked_0(locked_0),
        .sys_rst_n(sys_rst_n), .periph_rst_n(periph_rst_n), .ready(ready),
        .lock_lost(lock_lost), .loss_count(loss_count), .state_o(state_o)
    );

    lock_reset_sequencer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .RST_HOLD_CYCLES(RH), .LOSS_CNT_W(2)) dut_b (
        .clk_0(clk_0), .rst_n_0(rst_n_0), .locked_0(locked_0),
        .sys_rst_n(b_sys_rst_n), .periph_rst_n(b_periph_rst_n), .ready(b_ready),
        .lock_lost(b_lock_lost), .loss_count(b_loss_count), .state_o(b_state_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int q[$];        // last SS sampled locked_0 values, index 0 newest
    int run;         // consecutive edges with synced lock high since restart
    int in_lost;     // a loss was just detected; next edge restarts
    int losses;      // total loss events since reset

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q = {};
        for (int i = 0; i < SS; i++) q.push_back(0);
        run     = 0;
        in_lost = 0;
        losses  = 0;
    endtask

    task automatic model_edge(input logic l);
        int ls;
        ls = q[SS-1];
        q.push_front(int'(l));
        void'(q.pop_back());
        if (in_lost != 0) begin
            in_lost = 0;
            run     = 0;
        end else if (ls != 0) begin
            run = (run + 1 > SC + RH + 1) ? SC + RH + 1 : run + 1;
        end else begin
            // Losing lock only counts once the system reset was released.
            if (run >= SC + 1) begin
                in_lost = 1;
                losses++;
            end
            run = 0;
        end
    endtask

    function automatic int exp_state();
        if (in_lost != 0)      return 4;
        if (run == 0)          return 0;
        if (run <= SC)         return 1;
        if (run <= SC + RH)    return 2;
        return 3;
    endfunction

    task automatic check_all();
        int s;
        s = exp_state();
        chk("state",        32'(state_o),      32'(s));
        chk("sys_rst_n",    32'(sys_rst_n),    32'(s == 2 || s == 3));
        chk("periph_rst_n", 32'(periph_rst_n), 32'(s == 3));
        chk("ready",        32'(ready),        32'(s == 3));
        chk("lock_lost",    32'(lock_lost),    32'(s == 4));
        chk("loss_count",   32'(loss_count),   32'((losses > 255) ? 255 : losses));
        chk("b_state",      32'(b_state_o),    32'(s));
        chk("b_loss_count", 32'(b_loss_count), 32'((losses > 3) ? 3 : losses));
    endtask

    task automatic step();
        @(posedge clk_0);
        model_edge(locked_0);
        #1;
        check_all();
    endtask

    initial begin
        int first_sys, first_per, first_lost, lost_cycles, saw_sys, hi, lo;

        // 1: reset, no lock.
        rst_n_0  = 1'b0;
        locked_0 = 1'b0;
        model_reset();
        #12;
        check_all();
        @(posedge clk_0);
        #1 rst_n_0 = 1'b1;
        repeat (50) step();
        $display("phase 1 reset/no-lock done, checks=%0d", checks);

        // 3: short lock pulse never releases anything.
        locked_0 = 1'b1;
        saw_sys  = 0;
        repeat (10) begin
            step();
            if (sys_rst_n !== 1'b0) saw_sys = 1;
        end
        locked_0 = 1'b0;
        repeat (20) begin
            step();
            if (sys_rst_n !== 1'b0) saw_sys = 1;
        end
        chk("short_pulse_no_release", 32'(saw_sys), 32'd0);
        chk("short_pulse_state", 32'(state_o), 32'd0);
        chk("short_pulse_loss", 32'(loss_count), 32'd0);
        $display("phase 3 short pulse done, checks=%0d", checks);

        // 2: full release sequence; locked_0 changes just after edge 0.
        locked_0  = 1'b1;
        first_sys = -1;
        first_per = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (first_sys < 0 && sys_rst_n === 1'b1) first_sys = n;
            if (first_per < 0 && periph_rst_n === 1'b1) first_per = n;
        end
        chk("sys_latency", 32'(first_sys), 32'(SS + 1 + SC));
        chk("periph_latency", 32'(first_per), 32'(SS + 1 + SC + RH));
        chk("run_state", 32'(state_o), 32'd3);
        $display("phase 2 lock release done, checks=%0d", checks);

        // 4: loss from RUN, then relock with identical latencies.
        locked_0    = 1'b0;
        first_lost  = -1;
        lost_cycles = 0;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (lock_lost === 1'b1) begin
                lost_cycles++;
                if (first_lost < 0) first_lost = n;
            end
        end
        chk("lost_latency", 32'(first_lost), 32'(SS + 1));
        chk("lost_width", 32'(lost_cycles), 32'd1);
        chk("loss_after_drop", 32'(loss_count), 32'd1);
        locked_0  = 1'b1;
        first_sys = -1;
        first_per = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (first_sys < 0 && sys_rst_n === 1'b1) first_sys = n;
            if (first_per < 0 && periph_rst_n === 1'b1) first_per = n;
        end
        chk("relock_sys_latency", 32'(first_sys), 32'(SS + 1 + SC));
        chk("relock_periph_latency", 32'(first_per), 32'(SS + 1 + SC + RH));
        $display("phase 4 loss and relock done, checks=%0d", checks);

        // 5: five more losses from RUN; narrow counter saturates.
        repeat (5) begin
            locked_0 = 1'b0;
            repeat (6) step();
            locked_0 = 1'b1;
            repeat (SS + SC + RH + 4) step();
        end
        chk("loss_count_6", 32'(loss_count), 32'd6);
        chk("b_loss_saturated", 32'(b_loss_count), 32'd3);
        $display("phase 5 saturation done, checks=%0d", checks);

        // Randomized lock/unlock durations against the model.
        for (int k = 0; k < 40; k++) begin
            hi = int'($urandom_range(1, 36));
            lo = int'($urandom_range(1, 8));
            locked_0 = 1'b1;
            repeat (hi) step();
            locked_0 = 1'b0;
            repeat (lo) step();
        end
        $display("random phase done, losses=%0d checks=%0d", losses, checks);

        // 6: asynchronous reset in the middle of REL_SYS.
        locked_0 = 1'b1;
        repeat (SS + SC + 4) step();
        chk("in_rel_sys", 32'(state_o), 32'd2);
        @(negedge clk_0);
        #2 rst_n_0 = 1'b0;
        model_reset();
        #1;
        chk("async_sys_rst_n", 32'(sys_rst_n), 32'd0);
        chk("async_state", 32'(state_o), 32'd0);
        chk("async_loss", 32'(loss_count), 32'd0);
        @(posedge clk_0);
        #1 rst_n_0 = 1'b1;
        check_all();
        first_sys = -1;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (first_sys < 0 && sys_rst_n === 1'b1) first_sys = n;
        end
        chk("post_reset_sys_latency", 32'(first_sys), 32'(SS + 1 + SC));
        $display("phase 6 async reset done, checks=%0d", checks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
